// File: rtl/bus_cycle_ctrl.sv
// rtl/bus_cycle_ctrl.sv - Bus cycle controller sequencing IDLE/T1/T2/T3/TW/T4 memory cycles
//
// Purpose: accepts a read, write or instruction-fetch request and runs one
// external bus cycle. T1 latches the address (ale). T2/T3 assert the read or
// write strobe. Optional TW wait states follow T3 until ready. T4 completes
// the cycle with ack, plus q_push for instruction fetches.
//
// Configuration macro: WAIT_STATE_EN
//   defined   - ready is honoured and TW inserts wait states
//   undefined - ready is ignored, every cycle is exactly T1..T4
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   req       in   cycle request, sampled in IDLE only
//   wr        in   1 = write, 0 = read
//   fetch     in   read is an instruction fetch (ignored for writes)
//   addr      in   [19:0] physical address
//   wdata     in   [7:0] write byte
//   q_full    in   prefetch queue full
//   ready     in   external memory ready
//   din       in   [7:0] external data bus input
//   addr_out  out  [19:0] latched bus address
//   ale       out  address latch enable
//   rd_n      out  active-low read strobe
//   wr_n      out  active-low write strobe
//   dout      out  [7:0] write data
//   dout_oe   out  data driver enable
//   rdata     out  [7:0] captured read byte
//   ack       out  cycle-complete pulse
//   q_push    out  prefetch queue push pulse
//   busy      out  high outside IDLE
module bus_cycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic        fetch,
  input  logic [19:0] addr,
  input  logic [7:0]  wdata,
  input  logic        q_full,
  input  logic        ready,
  input  logic [7:0]  din,
  output logic [19:0] addr_out,
  output logic        ale,
  output logic        rd_n,
  output logic        wr_n,
  output logic [7:0]  dout,
  output logic        dout_oe,
  output logic [7:0]  rdata,
  output logic        ack,
  output logic        q_push,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_TW   = 3'd4,
    S_T4   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        wr_q;
  logic        fetch_q;
  logic        accept;
  logic        mem_ready;

  // A fetch cannot start while the prefetch queue has no room for its byte.
  assign accept = req && !(!wr && fetch && q_full);

`ifdef WAIT_STATE_EN
  assign mem_ready = ready;
`else
  logic unused_ready;
  assign unused_ready = ready;
  assign mem_ready    = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (accept) state_d = S_T1;
      S_T1:        state_d = S_T2;
      S_T2:        state_d = S_T3;
      S_T3, S_TW:  state_d = mem_ready ? S_T4 : S_TW;
      S_T4:        state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Cycle attributes are frozen at acceptance; rdata samples din on entry to T4.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      fetch_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        wr_q    <= wr;
        fetch_q <= fetch && !wr;
      end
      if ((state_q == S_T3 || state_q == S_TW) && state_d == S_T4 && !wr_q)
        rdata_q <= din;
    end
  end

  // Output logic: decoded from state so reset clears strobes immediately.
  always_comb begin
    ale     = 1'b0;
    rd_n    = 1'b1;
    wr_n    = 1'b1;
    dout    = '0;
    dout_oe = 1'b0;
    ack     = 1'b0;
    q_push  = 1'b0;
    busy    = (state_q != S_IDLE);
    case (state_q)
      S_T1: ale = 1'b1;
      S_T2, S_T3, S_TW: begin
        if (wr_q) begin
          wr_n    = 1'b0;
          dout_oe = 1'b1;
          dout    = wdata_q;
        end else begin
          rd_n = 1'b0;
        end
      end
      S_T4: begin
        ack    = 1'b1;
        q_push = fetch_q;
      end
      default: ;
    endcase
  end

  assign addr_out = addr_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb/tb_bus_cycle_ctrl.sv - Directed self-checking bench for bus_cycle_ctrl
module tb_bus_cycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic        fetch = 1'b0;
  logic [19:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        q_full = 1'b0;
  logic        ready = 1'b1;
  logic [7:0]  din = '0;
  logic [19:0] addr_out;
  logic        ale, rd_n, wr_n, dout_oe, ack, q_push, busy;
  logic [7:0]  dout, rdata;

  int checks = 0;
  int failures = 0;

  bus_cycle_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .fetch(fetch),
    .addr(addr), .wdata(wdata), .q_full(q_full), .ready(ready), .din(din),
    .addr_out(addr_out), .ale(ale), .rd_n(rd_n), .wr_n(wr_n), .dout(dout),
    .dout_oe(dout_oe), .rdata(rdata), .ack(ack), .q_push(q_push), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({ale, rd_n, wr_n, dout_oe, ack, q_push, busy} !== 7'b0110000 ||
        dout !== 8'h00 || addr_out !== 20'h0 || rdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_values: ale=%b rd_n=%b wr_n=%b oe=%b ack=%b qp=%b busy=%b dout=%h addr=%h rdata=%h, want 0 1 1 0 0 0 0 00 00000 00",
               ale, rd_n, wr_n, dout_oe, ack, q_push, busy, dout, addr_out, rdata);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch_read();
    req = 1'b1; wr = 1'b0; fetch = 1'b1; addr = 20'h12345; din = 8'hB8; ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // later input changes must not disturb the running cycle
        req = 1'b0; wr = 1'b1; fetch = 1'b0; addr = 20'h0ABCD;
      end
      checks++;
      if (ale !== (k == 1) || rd_n !== !(k == 2 || k == 3) || wr_n !== 1'b1 ||
          ack !== (k == 4) || q_push !== (k == 4) || busy !== 1'b1 || addr_out !== 20'h12345) begin
        failures++;
        $display("FAIL fetch_read_c%0d: ale=%b rd_n=%b wr_n=%b ack=%b qp=%b busy=%b addr=%h",
                 k, ale, rd_n, wr_n, ack, q_push, busy, addr_out);
      end
    end
    checks++;
    if (rdata !== 8'hB8) begin
      failures++;
      $display("FAIL fetch_read_rdata: got %h want b8", rdata);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ack !== 1'b0 || q_push !== 1'b0) begin
      failures++;
      $display("FAIL fetch_read_idle: busy=%b ack=%b qp=%b want 0 0 0", busy, ack, q_push);
    end
  endtask

  task automatic test_write();
    req = 1'b1; wr = 1'b1; fetch = 1'b1; addr = 20'hFFFFF; wdata = 8'h5A;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin req = 1'b0; wdata = 8'h00; end
      checks++;
      if (ale !== (k == 1) || wr_n !== !(k == 2 || k == 3) || rd_n !== 1'b1 ||
          dout_oe !== (k == 2 || k == 3) || dout !== ((k == 2 || k == 3) ? 8'h5A : 8'h00) ||
          ack !== (k == 4) || q_push !== 1'b0 || addr_out !== 20'hFFFFF) begin
        failures++;
        $display("FAIL write_c%0d: ale=%b wr_n=%b rd_n=%b oe=%b dout=%h ack=%b qp=%b addr=%h",
                 k, ale, wr_n, rd_n, dout_oe, dout, ack, q_push, addr_out);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_wait_states();
    int exp_ack;
    logic [7:0] exp_rdata;
    logic seen;
`ifdef WAIT_STATE_EN
    exp_ack = 7; exp_rdata = 8'h77;
`else
    exp_ack = 4; exp_rdata = 8'h11;
`endif
    seen = 1'b0;
    req = 1'b1; wr = 1'b0; fetch = 1'b0; addr = 20'h00400; ready = 1'b1; din = 8'h00;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) req = 1'b0;
      if (k == 3) begin ready = 1'b0; din = 8'h11; end
      if (k == 6) begin ready = 1'b1; din = 8'h77; end
      if (ack === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (k != exp_ack || rdata !== exp_rdata) begin
          failures++;
          $display("FAIL wait_ack: ack at cycle %0d rdata=%h, want cycle %0d rdata=%h", k, rdata, exp_ack, exp_rdata);
        end
      end else if (k >= 2 && k < exp_ack) begin
        checks++;
        if (rd_n !== 1'b0) begin
          failures++;
          $display("FAIL wait_strobe_c%0d: rd_n=%b want 0", k, rd_n);
        end
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL wait_ack_timeout: no ack within 8 cycles, want cycle %0d", exp_ack);
    end
    ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_blocked_fetch();
    req = 1'b1; wr = 1'b0; fetch = 1'b1; q_full = 1'b1; addr = 20'h00777; din = 8'h3C;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ale !== 1'b0) begin
        failures++;
        $display("FAIL blocked_c%0d: busy=%b ale=%b want 0 0", k, busy, ale);
      end
    end
    q_full = 1'b0;
    @(negedge clk);
    req = 1'b0;
    checks++;
    if (busy !== 1'b1 || ale !== 1'b1 || addr_out !== 20'h00777) begin
      failures++;
      $display("FAIL blocked_release: busy=%b ale=%b addr=%h want 1 1 00777", busy, ale, addr_out);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ack !== 1'b1 || q_push !== 1'b1 || rdata !== 8'h3C) begin
      failures++;
      $display("FAIL blocked_complete: ack=%b qp=%b rdata=%h want 1 1 3c", ack, q_push, rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    req = 1'b1; wr = 1'b1; fetch = 1'b0; addr = 20'h11111; wdata = 8'hC3;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 4) addr = 20'h22222;
      if (k == 6) req = 1'b0;
      checks++;
      if (ale !== (k == 1 || k == 6) || busy !== (k != 5) || ack !== (k == 4) ||
          addr_out !== ((k == 6) ? 20'h22222 : 20'h11111)) begin
        failures++;
        $display("FAIL back_to_back_c%0d: ale=%b busy=%b ack=%b addr=%h", k, ale, busy, ack, addr_out);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_cycle();
    req = 1'b1; wr = 1'b0; fetch = 1'b1; q_full = 1'b0; addr = 20'h0F0F0; din = 8'h99;
    repeat (2) @(negedge clk);
    req = 1'b0;
    checks++;
    if (rd_n !== 1'b0) begin
      failures++;
      $display("FAIL abort_t2_strobe: rd_n=%b want 0", rd_n);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (rd_n !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_immediate: rd_n=%b busy=%b want 1 0", rd_n, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (ack !== 1'b0 || q_push !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_after_c%0d: ack=%b qp=%b busy=%b want 0 0 0", k, ack, q_push, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_write();
    test_wait_states();
    test_blocked_fetch();
    test_back_to_back();
    test_reset_mid_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_cycle_ctrl.md
BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

Interface
REQ-001 The block SHALL have one clock and reset SHALL be asynchronous and active-low; ports are named clk and reset as elsewhere in the design.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req  input  1  bus cycle request, level-sensitive, sampled only in IDLE.
REQ-005 wr  input  1  1 = write cycle, 0 = read cycle.
REQ-006 fetch  input  1  1 = the read is an instruction fetch destined for the prefetch queue; ignored when wr=1.
REQ-007 addr  input  20  physical address from the address ALU (Direction).
REQ-008 wdata  input  8  write byte.
REQ-009 q_full  input  1  prefetch queue full.
REQ-010 ready  input  1  external memory ready.
REQ-011 din  input  8  external data bus, input side.
REQ-012 addr_out  output  20  latched bus address.
REQ-013 ale  output  1  address latch enable.
REQ-014 rd_n / wr_n  output  1 each  active-low read and write strobes.
REQ-015 dout  output  8  write data; dout_oe  output  1  enables the data driver.
REQ-016 rdata  output  8  captured read byte.
REQ-017 ack  output  1  one-cycle cycle-complete pulse.
REQ-018 q_push  output  1  one-cycle pulse that drives the queue EN.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 The FSM SHALL have the states IDLE, T1, T2, T3, TW and T4.
REQ-021 In IDLE, req=1 SHALL be accepted unless wr=0, fetch=1 and q_full=1 (blocked fetch); a blocked request SHALL leave the FSM in IDLE.
REQ-022 On acceptance, addr, wr, wdata and fetch SHALL be latched; addr_out SHALL take the latched address and hold it until the next acceptance.
REQ-023 Sequence: IDLE -> T1 -> T2 -> T3 -> T4 -> IDLE; if the acceptance edge is cycle 0, ack SHALL be high in cycle 4 with no wait states.
REQ-024 T1: ale=1; all other strobes inactive.
REQ-025 T2 and T3 (and TW): read -> rd_n=0; write -> wr_n=0, dout_oe=1, dout=latched wdata.
REQ-026 At the end of T3: ready=1 -> T4; ready=0 -> TW (REQ-034). TW SHALL repeat while ready=0 and go to T4 when ready=1.
REQ-027 For a read, rdata SHALL capture din on the edge leaving T3 or TW into T4.
REQ-028 T4: strobes and dout_oe inactive; ack=1; q_push=1 only for a read with fetch=1.
REQ-029 T4 SHALL always return to IDLE, so back-to-back cycles have exactly one IDLE cycle between them.
REQ-030 Inputs changing after acceptance SHALL have no effect on the cycle in progress.

Reset
REQ-031 reset=0 SHALL force IDLE asynchronously, from any state.
REQ-032 Reset values: ale=0, rd_n=1, wr_n=1, dout_oe=0, dout=0, addr_out=0, rdata=0, ack=0, q_push=0, busy=0.
REQ-033 Reset mid-cycle SHALL deassert the strobes immediately, and no ack or q_push SHALL follow for the aborted cycle.

Configuration
REQ-034 Macro WAIT_STATE_EN: when defined, ready SHALL be honoured and TW used; when undefined, ready SHALL be ignored, TW SHALL be unreachable, and every cycle SHALL be exactly T1-T4.

Verification
REQ-035 Fetch read: addr=0x12345, fetch=1, din=0xB8, ready=1 -> ale in cycle 1, rd_n low in cycles 2-3, rdata=0xB8, ack=q_push=1 in cycle 4.
REQ-036 Write: addr=0xFFFFF, wdata=0x5A -> wr_n low and dout_oe=1 with dout=0x5A in cycles 2-3, ack in cycle 4, q_push stays 0.
REQ-037 Wait states with WAIT_STATE_EN: ready=0 for 3 cycles from T3 -> 3 TW cycles, ack in cycle 7, rdata = din at the ready=1 edge; without the macro, ack in cycle 4.
REQ-038 Blocked fetch: q_full=1, req=1, fetch=1 -> busy stays 0 for 10 cycles; dropping q_full -> cycle starts the next edge.
REQ-039 Reset asserted in T2 of a read -> rd_n=1 and busy=0 immediately; no ack or q_push after reset is released.
